// File: rtl/exec_replica_monitor.sv
// rtl/exec_replica_monitor.sv - launch/capture checker for the exec-stage delay replica
// Counts replica timing faults per window and raises a sticky slow flag.
module exec_replica_monitor #(
   parameter int PARITY = 0,
   parameter int WINDOW = 256,
   parameter int THRESH = 4,
   parameter int CNT_W  = 16,
   localparam int WE_W  = $clog2(WINDOW + 1),
   localparam int WC_W  = $clog2(WINDOW)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             clear_i,
   output logic             replica_in_o,
   input  logic             replica_out_i,
   output logic             error_o,
   output logic [WE_W-1:0]  win_errs_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic             slow_o,
   output logic             window_done_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t            state;
   logic              arm_second;
   logic              launch_q;
   logic              launch_vld;
   logic              cap_q;
   logic              exp_q;
   logic              vld_q;
   logic [WC_W-1:0]   win_cnt;

   logic              go;
   logic              cmp;
   logic              mism;
   logic              win_end;
   logic [WE_W:0]     werr_inc;
   logic              thresh_hit;

   // A disable takes effect at the very edge it is sampled: no launch, no compare.
   assign go         = enable_i && (state != IDLE);
   assign cmp        = enable_i && (state == RUN) && vld_q;
   assign mism       = cap_q != exp_q;
   assign win_end    = cmp && (win_cnt == WC_W'(WINDOW - 1));
   assign werr_inc   = {1'b0, win_errs_o} + (WE_W + 1)'(mism);
   assign thresh_hit = werr_inc >= (WE_W + 1)'(THRESH);

   assign replica_in_o = launch_q;

   // Capture flop sits directly on the replica output so the path length is the replica alone.
   always_ff @(posedge clk_i) begin
      cap_q <= replica_out_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         arm_second    <= 1'b0;
         launch_q      <= 1'b0;
         launch_vld    <= 1'b0;
         exp_q         <= 1'b0;
         vld_q         <= 1'b0;
         win_cnt       <= '0;
         error_o       <= 1'b0;
         window_done_o <= 1'b0;
         win_errs_o    <= '0;
         err_count_o   <= '0;
         slow_o        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable_i) begin
                  state      <= ARM;
                  arm_second <= 1'b0;
               end
            end
            ARM: begin
               if (!enable_i)
                  state <= IDLE;
               else if (arm_second)
                  state <= RUN;
               else
                  arm_second <= 1'b1;
            end
            RUN: begin
               if (!enable_i)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (go)
            launch_q <= ~launch_q;
         launch_vld <= go;
         exp_q      <= launch_q ^ 1'(PARITY);
         vld_q      <= launch_vld && enable_i;

         error_o       <= 1'b0;
         window_done_o <= 1'b0;

         // Clear wins over a coincident error or window end; that compare is simply lost.
         if (clear_i) begin
            win_cnt     <= '0;
            win_errs_o  <= '0;
            err_count_o <= '0;
            slow_o      <= 1'b0;
         end else if ((state == IDLE) && enable_i) begin
            win_cnt <= '0;
         end else if (cmp) begin
            if (win_end) begin
               win_cnt       <= '0;
               win_errs_o    <= '0;
               window_done_o <= 1'b1;
               if (thresh_hit)
                  slow_o <= 1'b1;
            end else begin
               win_cnt <= win_cnt + WC_W'(1);
               if (mism)
                  win_errs_o <= win_errs_o + WE_W'(1);
            end
            if (mism) begin
               error_o <= 1'b1;
               if (err_count_o != {CNT_W{1'b1}})
                  err_count_o <= err_count_o + CNT_W'(1);
            end
         end
      end
   end

endmodule
